// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue boundary.
// Opcodes, operand selects and the ALU operation encoding.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_SLA
  } alu_op_t;

  typedef enum logic [1:0] {
    A_RS1,
    A_PC,
    A_ZERO
  } a_sel_t;

  typedef enum logic [1:0] {
    B_RS2,
    B_IMM_I,
    B_IMM_U,
    B_SHAMT
  } b_sel_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // alt picks SUB/SRA; the caller decides when alt is meaningful
  function automatic alu_op_t f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of RV32I ALU-class instructions.
// Produces the operation, operand selects and immediate.
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     alu_op,
  output a_sel_t      a_sel,
  output b_sel_t      b_sel,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_sh;
  logic       unused;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign is_sh  = (f3 == 3'b001) || (f3 == 3'b101);
  assign unused = ^{instr[19:15], instr[11:7]};

  always_comb begin
    alu_op  = ALU_NONE;
    a_sel   = A_RS1;
    b_sel   = B_RS2;
    imm     = '0;
    illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        alu_op = f3_op(f3, instr[30]);
        b_sel  = is_sh ? B_SHAMT : B_RS2;
      end
      OPC_OP_IMM: begin
        // immediate shifts fold the 5-bit shamt into imm
        alu_op = f3_op(f3, (f3 == 3'b101) && instr[30]);
        b_sel  = B_IMM_I;
        imm    = is_sh ? {27'b0, instr[24:20]}
                       : {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LUI: begin
        alu_op = ALU_ADD;
        a_sel  = A_ZERO;
        b_sel  = B_IMM_U;
        imm    = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        alu_op = ALU_ADD;
        a_sel  = A_PC;
        b_sel  = B_IMM_U;
        imm    = {instr[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ID/EX register for ALU operands with valid/ready handshake,
// flush/stall handling and an issued-instruction counter.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output alu_op_t          alu_op,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic [4:0]       rd,
  output logic             wb_en,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt
);

  alu_op_t          dec_op;
  a_sel_t           a_sel;
  b_sel_t           b_sel;
  logic [31:0]      imm;
  logic             dec_ill;
  logic [31:0]      a_mux;
  logic [31:0]      b_mux;

  logic             valid_q, valid_d;
  alu_op_t          op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic             wb_q, wb_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             fire;

  alu_decode u_dec (
    .instr   (instr),
    .alu_op  (dec_op),
    .a_sel   (a_sel),
    .b_sel   (b_sel),
    .imm     (imm),
    .illegal (dec_ill)
  );

  always_comb begin
    case (a_sel)
      A_RS1:   a_mux = rs1_data;
      A_PC:    a_mux = pc;
      default: a_mux = '0;
    endcase
    case (b_sel)
      B_RS2:   b_mux = rs2_data;
      B_SHAMT: b_mux = {27'b0, rs2_data[4:0]};
      default: b_mux = imm;
    endcase
  end

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = valid_q && out_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q + CNT_W'(fire);
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      a_d     = a_mux;
      b_d     = b_mux;
      rd_d    = instr[11:7];
      wb_d    = !dec_ill && (instr[11:7] != 5'd0);
      ill_d   = dec_ill;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= ALU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_op    = op_q;
  assign op_a      = a_q;
  assign op_b      = b_q;
  assign rd        = rd_q;
  assign wb_en     = wb_q;
  assign illegal   = ill_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode, handshake, stall,
// flush, illegal entries and reset during a stall.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  alu_op_t     alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd;
  logic        wb_en;
  logic        illegal;
  logic [31:0] issue_cnt;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  alu_issue #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd        (rd),
    .wb_en     (wb_en),
    .illegal   (illegal),
    .issue_cnt (issue_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p);
    in_valid = 1'b1;
    instr    = i;
    rs1_data = a;
    rs2_data = b;
    pc       = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    #12;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    nvec++; if (alu_op !== ALU_NONE) begin nerr++; $display("FAIL rst_op got %0d want %0d", alu_op, ALU_NONE); end
    nvec++; if ({op_a, op_b} !== 64'd0) begin nerr++; $display("FAIL rst_ops got %h/%h want 0/0", op_a, op_b); end
    nvec++; if ({rd, wb_en, illegal} !== 7'd0) begin nerr++; $display("FAIL rst_rd_wb_ill got %0d/%0b/%0b want 0/0/0", rd, wb_en, illegal); end
    nvec++; if (issue_cnt !== 32'd0) begin nerr++; $display("FAIL rst_cnt got %0d want 0", issue_cnt); end
    rst = 1'b0;
    exp_cnt = 0;
    step();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(32'h002081B3, 32'd5, 32'd7, 32'h0);
    step();
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL add_valid got %0b want 1", out_valid); end
    nvec++; if (alu_op !== ALU_ADD) begin nerr++; $display("FAIL add_op got %0d want %0d", alu_op, ALU_ADD); end
    nvec++; if (op_a !== 32'd5 || op_b !== 32'd7) begin nerr++; $display("FAIL add_ops got %h/%h want 5/7", op_a, op_b); end
    nvec++; if (rd !== 5'd3 || wb_en !== 1'b1) begin nerr++; $display("FAIL add_rd got %0d/%0b want 3/1", rd, wb_en); end
    nvec++; if (issue_cnt !== exp_cnt) begin nerr++; $display("FAIL add_cnt_pre got %0d want %0d", issue_cnt, exp_cnt); end
    step();
    exp_cnt++;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL add_drain got %0b want 0", out_valid); end
    nvec++; if (issue_cnt !== exp_cnt) begin nerr++; $display("FAIL add_cnt got %0d want %0d", issue_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vi [7] = '{32'h40335293, 32'h403100B3, 32'h4062D233,
                            32'hFFF00393, 32'h40000393, 32'h123450B7,
                            32'h00001117};
    logic [31:0] va [7] = '{32'h80000000, 32'd50, 32'hDEAD0000,
                            32'd9, 32'd1, 32'hAAAA5555, 32'd0};
    logic [31:0] vb [7] = '{32'h0000FFFF, 32'd8, 32'h00000025,
                            32'd3, 32'd2, 32'h5555AAAA, 32'd0};
    alu_op_t     eo [7] = '{ALU_SRA, ALU_SUB, ALU_SRA, ALU_ADD,
                            ALU_ADD, ALU_ADD, ALU_ADD};
    logic [31:0] ea [7] = '{32'h80000000, 32'd50, 32'hDEAD0000,
                            32'd9, 32'd1, 32'd0, 32'h100};
    logic [31:0] eb [7] = '{32'd3, 32'd8, 32'd5, 32'hFFFFFFFF,
                            32'h400, 32'h12345000, 32'h1000};
    logic [4:0]  er [7] = '{5'd5, 5'd1, 5'd4, 5'd7, 5'd7, 5'd1, 5'd2};
    logic [31:0] base;
    base = exp_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(vi[i], va[i], vb[i], 32'h100);
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready[%0d] got %0b want 1", i, in_ready); end
      step();
      nvec++; if (out_valid !== 1'b1 || alu_op !== eo[i]) begin nerr++; $display("FAIL b2b_op[%0d] got v=%0b op=%0d want v=1 op=%0d", i, out_valid, alu_op, eo[i]); end
      nvec++; if (op_a !== ea[i] || op_b !== eb[i]) begin nerr++; $display("FAIL b2b_ops[%0d] got %h/%h want %h/%h", i, op_a, op_b, ea[i], eb[i]); end
      nvec++; if (rd !== er[i] || wb_en !== 1'b1) begin nerr++; $display("FAIL b2b_rd[%0d] got %0d/%0b want %0d/1", i, rd, wb_en, er[i]); end
      nvec++; if (issue_cnt !== base + 32'(i)) begin nerr++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, issue_cnt, base + 32'(i)); end
    end
    in_valid = 1'b0;
    step();
    exp_cnt = base + 7;
    nvec++; if (out_valid !== 1'b0 || issue_cnt !== exp_cnt) begin nerr++; $display("FAIL b2b_end got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid, issue_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd11, 32'd22, 32'h0);
    step();
    drive(32'h0020C4B3, 32'h000000F0, 32'h0000000F, 32'h0);
    for (int c = 0; c < 3; c++) begin
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_ready[%0d] got %0b want 0", c, in_ready); end
      step();
      nvec++; if (out_valid !== 1'b1 || alu_op !== ALU_ADD || op_a !== 32'd11 || op_b !== 32'd22 || rd !== 5'd3) begin nerr++; $display("FAIL stall_hold[%0d] got v=%0b op=%0d %h/%h rd=%0d want v=1 op=%0d 11/22 rd=3", c, out_valid, alu_op, op_a, op_b, rd, ALU_ADD); end
      nvec++; if (issue_cnt !== exp_cnt) begin nerr++; $display("FAIL stall_cnt[%0d] got %0d want %0d", c, issue_cnt, exp_cnt); end
    end
    out_ready = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL stall_release got %0b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    exp_cnt++;
    nvec++; if (out_valid !== 1'b1 || alu_op !== ALU_XOR || op_a !== 32'hF0 || op_b !== 32'h0F || rd !== 5'd9) begin nerr++; $display("FAIL stall_next got v=%0b op=%0d %h/%h rd=%0d want v=1 op=%0d f0/0f rd=9", out_valid, alu_op, op_a, op_b, rd, ALU_XOR); end
    nvec++; if (issue_cnt !== exp_cnt) begin nerr++; $display("FAIL stall_fire_cnt got %0d want %0d", issue_cnt, exp_cnt); end
    step();
    exp_cnt++;
    nvec++; if (out_valid !== 1'b0 || issue_cnt !== exp_cnt) begin nerr++; $display("FAIL stall_drain got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid, issue_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(32'h002081B3, 32'd1, 32'd2, 32'h0);
    step();
    flush = 1'b1;
    drive(32'h0020C4B3, 32'd3, 32'd4, 32'h0);
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL flush_ready got %0b want 0", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0 || issue_cnt !== exp_cnt) begin nerr++; $display("FAIL flush_kill got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid, issue_cnt, exp_cnt); end
    nvec++; if (alu_op !== ALU_ADD || op_a !== 32'd1 || op_b !== 32'd2) begin nerr++; $display("FAIL flush_data got op=%0d %h/%h want op=%0d 1/2", alu_op, op_a, op_b, ALU_ADD); end
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd6, 32'd6, 32'h0);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    nvec++; if (out_valid !== 1'b0 || issue_cnt !== exp_cnt) begin nerr++; $display("FAIL flush_stalled got v=%0b cnt=%0d want v=0 cnt=%0d", out_valid, issue_cnt, exp_cnt); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(32'h00000073, 32'd9, 32'd9, 32'h0);
    step();
    drive(32'h00000013, 32'd0, 32'd0, 32'h0);
    nvec++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_op !== ALU_NONE || wb_en !== 1'b0) begin nerr++; $display("FAIL ecall got v=%0b ill=%0b op=%0d wb=%0b want 1/1/%0d/0", out_valid, illegal, alu_op, wb_en, ALU_NONE); end
    step();
    in_valid = 1'b0;
    exp_cnt++;
    nvec++; if (illegal !== 1'b0 || alu_op !== ALU_ADD || wb_en !== 1'b0 || rd !== 5'd0) begin nerr++; $display("FAIL nop got ill=%0b op=%0d wb=%0b rd=%0d want 0/%0d/0/0", illegal, alu_op, wb_en, rd, ALU_ADD); end
    nvec++; if (issue_cnt !== exp_cnt) begin nerr++; $display("FAIL ill_cnt got %0d want %0d", issue_cnt, exp_cnt); end
    step();
    exp_cnt++;
    nvec++; if (issue_cnt !== exp_cnt) begin nerr++; $display("FAIL nop_cnt got %0d want %0d", issue_cnt, exp_cnt); end
  endtask

  task automatic test_rst_stall();
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd5, 32'd7, 32'h0);
    step();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    nvec++; if (out_valid !== 1'b0 || alu_op !== ALU_NONE || issue_cnt !== 32'd0) begin nerr++; $display("FAIL rst_async got v=%0b op=%0d cnt=%0d want 0/%0d/0", out_valid, alu_op, issue_cnt, ALU_NONE); end
    #1 rst = 1'b0;
    exp_cnt = 0;
    out_ready = 1'b1;
    drive(32'h002081B3, 32'd5, 32'd7, 32'h0);
    step();
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1 || op_a !== 32'd5 || op_b !== 32'd7 || issue_cnt !== 32'd0) begin nerr++; $display("FAIL rst_rearm got v=%0b %h/%h cnt=%0d want 1 5/7 0", out_valid, op_a, op_b, issue_cnt); end
    step();
    nvec++; if (issue_cnt !== 32'd1) begin nerr++; $display("FAIL rst_rearm_cnt got %0d want 1", issue_cnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_rst_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
